// File: rtl/ftsd_text_encoder_pkg.sv
// Shared font codes and controller state encodings for the text encoder.
package ftsd_text_encoder_pkg;

    localparam int FONT_W     = 6;
    localparam int NUM_DIGITS = 4;

    // Font codes: digits 0-9 start at FONT_ZERO, letters A-Z start at FONT_A.
    localparam logic [FONT_W-1:0] FONT_ZERO  = 6'd0;
    localparam logic [FONT_W-1:0] FONT_A     = 6'd10;
    localparam logic [FONT_W-1:0] FONT_BLANK = 6'd63;

    typedef enum logic [1:0] {
        FTE_IDLE  = 2'd0,
        FTE_COUNT = 2'd1,
        FTE_SHIFT = 2'd2
    } fte_state_e;

endpackage

// File: rtl/ftsd_text_encoder_font_fifo.sv
// Synchronous FIFO of 6-bit font codes with count-based full/empty flags.
module ftsd_text_encoder_font_fifo
    import ftsd_text_encoder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [FONT_W-1:0]        wdata_i,
    output logic [FONT_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [FONT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    // Flags come from the start-of-cycle count, so a pop while full frees space only next cycle.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; clear wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ftsd_text_encoder.sv
// ASCII-to-font encoder feeding a right-to-left scrolling 4-digit display buffer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FTE_IDLE  | FIFO empty, step counter held at 0, display holds content
// FTE_COUNT | counting tick pulses toward the next scroll step
// FTE_SHIFT | one cycle: pop FIFO head into digit 0, drop digit 3
module ftsd_text_encoder
    import ftsd_text_encoder_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int STEP_TICKS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         tick_i,
    input  logic                         clear_i,
    input  logic                         in_valid_i,
    input  logic [7:0]                   in_char_i,
    output logic                         in_ready_o,
    output logic [FONT_W*NUM_DIGITS-1:0] font_out_o,
    output logic                         busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);

    fte_state_e                   state_q;
    logic [CW-1:0]                cnt_q;
    logic [FONT_W*NUM_DIGITS-1:0] font_q;
    logic                         busy_q;

    logic [FONT_W-1:0] fifo_wdata;
    logic [FONT_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              fifo_pop;
    logic              push_ok;
    logic              more_after_pop;

    function automatic logic [FONT_W-1:0] ascii_to_font(input logic [7:0] ch);
        logic [FONT_W-1:0] code;
        code = FONT_BLANK;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            code = FONT_ZERO + FONT_W'(ch - 8'h30);
        end else if (ch >= 8'h41 && ch <= 8'h5A) begin
            code = FONT_A + FONT_W'(ch - 8'h41);
        end else if (ch >= 8'h61 && ch <= 8'h7A) begin
            code = FONT_A + FONT_W'(ch - 8'h61);
        end
        return code;
    endfunction

    assign fifo_wdata = ascii_to_font(in_char_i);
    assign in_ready_o = !fifo_full;
    assign push_ok    = in_valid_i && in_ready_o;
    assign fifo_pop   = (state_q == FTE_SHIFT);
    // A same-cycle push keeps the queue non-empty even when popping the last entry.
    assign more_after_pop = !((fifo_count == (AW+1)'(1)) && !push_ok);

    ftsd_text_encoder_font_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (in_valid_i),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Scroll sequencer with registered display buffer and busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FTE_IDLE;
            cnt_q   <= '0;
            font_q  <= {NUM_DIGITS{FONT_BLANK}};
            busy_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= FTE_IDLE;
            cnt_q   <= '0;
            font_q  <= {NUM_DIGITS{FONT_BLANK}};
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                FTE_IDLE: begin
                    cnt_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= FTE_COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                FTE_COUNT: begin
                    if (tick_i) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= FTE_SHIFT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FTE_SHIFT: begin
                    font_q <= {font_q[FONT_W*(NUM_DIGITS-1)-1:0], fifo_rdata};
                    if (more_after_pop) begin
                        state_q <= FTE_COUNT;
                    end else begin
                        state_q <= FTE_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FTE_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign font_out_o = font_q;
    assign busy_o     = busy_q;

endmodule
